// File: rtl/mesh_edge_injector.sv
// Credit-based packet injector for one open edge inport of the node mesh.
// Latches a whole host packet, then serialises it flit by flit as buffer credits allow.

`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 33
`endif

module mesh_edge_injector #(
    parameter int PACKET_FLITS = 5,
    parameter int BUFFER_DEPTH = 4,
    parameter int CNT_WIDTH    = 16,
    localparam int FLIT_W      = `CHANNEL_WIDTH - 1,
    localparam int CRED_W      = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pkt_valid_din,
    output logic                               pkt_ready_dout,
    input  logic [0:PACKET_FLITS*FLIT_W-1]     pkt_data_din,
    output logic [`CHANNEL_WIDTH-1:0]          channel_dout,
    input  logic                               credit_in_din,
    output logic                               busy_dout,
    output logic [CRED_W-1:0]                  credits_dout,
    output logic [CNT_WIDTH-1:0]               pkts_sent_dout,
    output logic                               credit_overflow_dout
);

    localparam int IDX_W = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]                     r_state;
    logic [IDX_W-1:0]               r_idx;
    logic [0:PACKET_FLITS*FLIT_W-1] r_pkt;
    logic [CRED_W-1:0]              r_credits;
    logic [`CHANNEL_WIDTH-1:0]      r_channel;
    logic                           r_busy;
    logic [CNT_WIDTH-1:0]           r_pkts_sent;
    logic                           r_overflow;

    logic                           w_accept;
    logic                           w_send;
    logic                           w_last;
    logic [FLIT_W-1:0]              w_flit;
    logic [CRED_W-1:0]              w_credits_nxt;
    logic                           w_overflow_evt;

    assign pkt_ready_dout = (r_state == S_IDLE);
    assign w_accept       = pkt_valid_din && pkt_ready_dout;
    assign w_send         = (r_state == S_SEND) && (r_credits != '0);
    assign w_last         = (r_idx == IDX_W'(PACKET_FLITS - 1));

    always_comb begin
        w_flit = '0;
        for (int unsigned i = 0; i < PACKET_FLITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_flit = r_pkt[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // A send and a returned credit in the same cycle cancel; a return at full count saturates.
    always_comb begin
        w_credits_nxt  = r_credits;
        w_overflow_evt = 1'b0;
        if (w_send && !credit_in_din) begin
            w_credits_nxt = r_credits - 1'b1;
        end else if (!w_send && credit_in_din) begin
            if (r_credits == CRED_W'(BUFFER_DEPTH)) begin
                w_overflow_evt = 1'b1;
            end else begin
                w_credits_nxt = r_credits + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_pkt       <= '0;
            r_credits   <= CRED_W'(BUFFER_DEPTH);
            r_channel   <= '0;
            r_busy      <= 1'b0;
            r_pkts_sent <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_credits <= w_credits_nxt;
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
            r_channel <= w_send ? {1'b1, w_flit} : '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pkt   <= pkt_data_din;
                        r_idx   <= '0;
                        r_state <= S_SEND;
                        r_busy  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_send) begin
                        if (w_last) begin
                            r_idx       <= '0;
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                            r_pkts_sent <= r_pkts_sent + 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign channel_dout         = r_channel;
    assign busy_dout            = r_busy;
    assign credits_dout         = r_credits;
    assign pkts_sent_dout       = r_pkts_sent;
    assign credit_overflow_dout = r_overflow;

endmodule

// File: tb/tb_mesh_edge_injector.sv
// Bench for mesh_edge_injector: cycle table for the basic packet, scoreboard for streaming cases.

`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 33
`endif

module tb_mesh_edge_injector;

    localparam int PF = 3;
    localparam int BD = 4;
    localparam int CW = 4;
    localparam int FW = `CHANNEL_WIDTH - 1;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      pkt_valid_din = 1'b0;
    logic                      pkt_ready_dout;
    logic [0:PF*FW-1]          pkt_data_din = '0;
    logic [`CHANNEL_WIDTH-1:0] channel_dout;
    logic                      credit_in_din = 1'b0;
    logic                      busy_dout;
    logic [2:0]                credits_dout;
    logic [CW-1:0]             pkts_sent_dout;
    logic                      credit_overflow_dout;

    mesh_edge_injector #(.PACKET_FLITS(PF), .BUFFER_DEPTH(BD), .CNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .pkt_valid_din        (pkt_valid_din),
        .pkt_ready_dout       (pkt_ready_dout),
        .pkt_data_din         (pkt_data_din),
        .channel_dout         (channel_dout),
        .credit_in_din        (credit_in_din),
        .busy_dout            (busy_dout),
        .credits_dout         (credits_dout),
        .pkts_sent_dout       (pkts_sent_dout),
        .credit_overflow_dout (credit_overflow_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        credit;
        logic [32:0] ch;
        logic [2:0]  cr;
        logic        busy;
        logic        rdy;
        logic [3:0]  pk;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          flits_seen = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    bit          mon_en = 1'b0;
    bit          echo = 1'b0;
    bit          full_chk = 1'b0;
    logic [31:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor at the falling edge, then advance to just after the next rising edge.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        if (mon_en) begin
            if (channel_dout[32]) begin
                if (sb.size() == 0) begin
                    chk("stray_flit", {31'b0, channel_dout}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("flit", {32'b0, channel_dout[31:0]}, {32'b0, e});
                end
                flits_seen++;
                if (flits_seen == 1) first_cyc = cyc;
                last_cyc = cyc;
            end else begin
                chk("bubble_zero", {31'b0, channel_dout}, 64'h0);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (full_chk) chk("credits_full", {61'b0, credits_dout}, 64'd4);
        if (echo) credit_in_din = busy_dout;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        echo = 1'b0;
        reset = 1'b1;
        pkt_valid_din = 1'b0;
        credit_in_din = 1'b0;
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic send_pkt(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int n = 0;
        while (pkt_ready_dout !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (pkt_ready_dout !== 1'b1) begin
            chk("ready_timeout", {63'b0, pkt_ready_dout}, 64'h1);
        end else begin
            pkt_data_din = {a, b, c};
            pkt_valid_din = 1'b1;
            sb.push_back(a);
            sb.push_back(b);
            sb.push_back(c);
            step();
            pkt_valid_din = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        chk("drain_left", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[8];
        int   n;
        tv[0] = '{1'b1, 1'b0, 33'h0,           3'd4, 1'b1, 1'b0, 4'd0};
        tv[1] = '{1'b0, 1'b0, {1'b1, 32'hA0A0_0001}, 3'd3, 1'b1, 1'b0, 4'd0};
        tv[2] = '{1'b0, 1'b0, {1'b1, 32'hB0B0_0002}, 3'd2, 1'b1, 1'b0, 4'd0};
        tv[3] = '{1'b0, 1'b0, {1'b1, 32'hC0C0_0003}, 3'd1, 1'b0, 1'b1, 4'd1};
        tv[4] = '{1'b0, 1'b0, 33'h0,           3'd1, 1'b0, 1'b1, 4'd1};
        tv[5] = '{1'b0, 1'b1, 33'h0,           3'd2, 1'b0, 1'b1, 4'd1};
        tv[6] = '{1'b0, 1'b1, 33'h0,           3'd3, 1'b0, 1'b1, 4'd1};
        tv[7] = '{1'b0, 1'b1, 33'h0,           3'd4, 1'b0, 1'b1, 4'd1};

        // Reset values
        do_reset();
        chk("rst_channel", {31'b0, channel_dout}, 64'h0);
        chk("rst_busy", {63'b0, busy_dout}, 64'h0);
        chk("rst_credits", {61'b0, credits_dout}, 64'd4);
        chk("rst_pkts", {60'b0, pkts_sent_dout}, 64'h0);
        chk("rst_ovf", {63'b0, credit_overflow_dout}, 64'h0);
        chk("rst_ready", {63'b0, pkt_ready_dout}, 64'h1);

        // Single packet, cycle by cycle
        pkt_data_din = {32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
        for (int i = 0; i < 8; i++) begin
            pkt_valid_din = tv[i].valid;
            credit_in_din = tv[i].credit;
            step();
            chk($sformatf("t1_ch_%0d", i), {31'b0, channel_dout}, {31'b0, tv[i].ch});
            chk($sformatf("t1_cr_%0d", i), {61'b0, credits_dout}, {61'b0, tv[i].cr});
            chk($sformatf("t1_busy_%0d", i), {63'b0, busy_dout}, {63'b0, tv[i].busy});
            chk($sformatf("t1_rdy_%0d", i), {63'b0, pkt_ready_dout}, {63'b0, tv[i].rdy});
            chk($sformatf("t1_pk_%0d", i), {60'b0, pkts_sent_dout}, {60'b0, tv[i].pk});
        end
        credit_in_din = 1'b0;
        chk("t1_ovf", {63'b0, credit_overflow_dout}, 64'h0);

        // Two packets with no credit return, then single-credit resumes
        do_reset();
        mon_en = 1'b1;
        flits_seen = 0;
        send_pkt(32'h1111_0000, 32'h1111_0001, 32'h1111_0002);
        send_pkt(32'h2222_0000, 32'h2222_0001, 32'h2222_0002);
        step();
        step();
        step();
        chk("t2_stall_credits", {61'b0, credits_dout}, 64'h0);
        chk("t2_stall_busy", {63'b0, busy_dout}, 64'h1);
        chk("t2_stall_channel", {31'b0, channel_dout}, 64'h0);
        chk("t2_flits_before_stall", 64'(flits_seen), 64'd4);
        credit_in_din = 1'b1;
        step();
        credit_in_din = 1'b0;
        chk("t2_pulse_credits", {61'b0, credits_dout}, 64'h1);
        chk("t2_pulse_channel", {31'b0, channel_dout}, 64'h0);
        step();
        chk("t2_resume_flit", {31'b0, channel_dout}, {31'b0, 1'b1, 32'h2222_0001});
        chk("t2_resume_credits", {61'b0, credits_dout}, 64'h0);
        credit_in_din = 1'b1;
        step();
        credit_in_din = 1'b0;
        step();
        drain();
        chk("t2_pkts", {60'b0, pkts_sent_dout}, 64'd2);
        chk("t2_busy_end", {63'b0, busy_dout}, 64'h0);

        // Credit returned on every send cycle: full count and one-cycle gap
        do_reset();
        mon_en = 1'b1;
        flits_seen = 0;
        echo = 1'b1;
        full_chk = 1'b1;
        for (int p = 0; p < 3; p++) begin
            send_pkt(32'h3300_0000 + 32'(p*16), 32'h3300_0001 + 32'(p*16), 32'h3300_0002 + 32'(p*16));
        end
        drain();
        echo = 1'b0;
        full_chk = 1'b0;
        credit_in_din = 1'b0;
        chk("t3_flits", 64'(flits_seen), 64'd9);
        chk("t3_span", 64'(last_cyc - first_cyc), 64'd10);
        chk("t3_pkts", {60'b0, pkts_sent_dout}, 64'd3);
        chk("t3_ovf", {63'b0, credit_overflow_dout}, 64'h0);

        // Credit return at full count while idle
        do_reset();
        mon_en = 1'b1;
        credit_in_din = 1'b1;
        step();
        credit_in_din = 1'b0;
        chk("t4_credits", {61'b0, credits_dout}, 64'd4);
        chk("t4_ovf_set", {63'b0, credit_overflow_dout}, 64'h1);
        step();
        step();
        step();
        chk("t4_ovf_sticky", {63'b0, credit_overflow_dout}, 64'h1);
        do_reset();
        chk("t4_ovf_cleared", {63'b0, credit_overflow_dout}, 64'h0);

        // Reset mid-packet aborts the remaining flit
        mon_en = 1'b1;
        send_pkt(32'h5500_0000, 32'h5500_0001, 32'h5500_0002);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        chk("t5_channel", {31'b0, channel_dout}, 64'h0);
        chk("t5_credits", {61'b0, credits_dout}, 64'd4);
        chk("t5_ready", {63'b0, pkt_ready_dout}, 64'h1);
        chk("t5_pkts", {60'b0, pkts_sent_dout}, 64'h0);
        chk("t5_busy", {63'b0, busy_dout}, 64'h0);
        send_pkt(32'h5600_0000, 32'h5600_0001, 32'h5600_0002);
        drain();
        chk("t5_pkts_after", {60'b0, pkts_sent_dout}, 64'd1);

        // Host keeps valid high with changing data during SEND
        do_reset();
        mon_en = 1'b1;
        pkt_data_din = {32'h6600_0000, 32'h6600_0001, 32'h6600_0002};
        pkt_valid_din = 1'b1;
        sb.push_back(32'h6600_0000);
        sb.push_back(32'h6600_0001);
        sb.push_back(32'h6600_0002);
        step();
        n = 0;
        while (busy_dout && n < 20) begin
            pkt_data_din = {$urandom, $urandom, $urandom};
            chk("t6_ready_low", {63'b0, pkt_ready_dout}, 64'h0);
            step();
            n++;
        end
        pkt_valid_din = 1'b0;
        chk("t6_busy_fell", {63'b0, busy_dout}, 64'h0);
        drain();
        chk("t6_pkts", {60'b0, pkts_sent_dout}, 64'd1);

        // Packet counter wraps at 2^CNT_WIDTH
        do_reset();
        mon_en = 1'b1;
        echo = 1'b1;
        for (int p = 0; p < 17; p++) begin
            send_pkt(32'h7700_0000 + 32'(p*4), 32'h7700_0001 + 32'(p*4), 32'h7700_0002 + 32'(p*4));
        end
        drain();
        echo = 1'b0;
        credit_in_din = 1'b0;
        chk("t7_pkts_wrap", {60'b0, pkts_sent_dout}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
